// File: rtl/m6502_instr_queue.sv
// 6502 fetch-side instruction assembler and decoder feeding a DEPTH-entry decoded queue.
// Optional feature macro: M6502_DECODE_ILLEGAL_TRAP_EN (trap unlisted opcodes and stop fetch until flush).
module m6502_instr_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [15:0] flush_pc,
  output logic [15:0] fetch_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_pc,
  output logic [7:0]  out_opcode,
  output logic [15:0] out_operand,
  output logic [1:0]  out_len,
  output logic [2:0]  out_opa,
  output logic [2:0]  out_opb,
  output logic [2:0]  out_alu_op,
  output logic [2:0]  out_dest,
  output logic        out_upd_carry,
  output logic        out_upd_zero,
  output logic        out_upd_overflow,
  output logic        out_illegal
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] SEL_AREG = 3'd0, SEL_XREG = 3'd1, SEL_YREG = 3'd2;
  localparam logic [2:0] SEL_MEM  = 3'd3, SEL_IMM  = 3'd4, SEL_ONE  = 3'd7;
  localparam logic [2:0] ALU_ADC  = 3'd1, ALU_SBC  = 3'd2;
  localparam logic [2:0] DST_MEM  = 3'd0, DST_AREG = 3'd1, DST_XREG = 3'd2;
  localparam logic [2:0] DST_YREG = 3'd3, DST_NONE = 3'd4;

  typedef enum logic [1:0] {S_OPC, S_OP1, S_OP2} state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  len;
    logic [2:0]  opa;
    logic [2:0]  opb;
    logic [2:0]  alu;
    logic [2:0]  dest;
    logic        upd_c;
    logic        upd_z;
    logic        upd_v;
    logic        illegal;
  } entry_t;

  function automatic entry_t decode(input logic [7:0] opc);
    entry_t e;
    e        = '0;
    e.opcode = opc;
    e.len    = 2'd1;
    e.dest   = DST_NONE;
    case (opc)
      8'h00, 8'h18, 8'h38, 8'h58, 8'h60, 8'h78, 8'h8A, 8'hAA, 8'hEA: ;
      8'hC8: begin e.opa = SEL_YREG; e.opb = SEL_ONE; e.alu = ALU_ADC; e.dest = DST_YREG; e.upd_z = 1'b1; end
      8'hCA: begin e.opa = SEL_XREG; e.opb = SEL_ONE; e.alu = ALU_SBC; e.dest = DST_XREG; e.upd_z = 1'b1; end
      8'hE8: begin e.opa = SEL_XREG; e.opb = SEL_ONE; e.alu = ALU_ADC; e.dest = DST_XREG; e.upd_z = 1'b1; end
      8'hA9: begin e.len = 2'd2; e.opa = SEL_IMM; e.dest = DST_AREG; e.upd_z = 1'b1; end
      8'h69: begin
        e.len = 2'd2; e.opa = SEL_AREG; e.opb = SEL_IMM; e.alu = ALU_ADC; e.dest = DST_AREG;
        e.upd_c = 1'b1; e.upd_z = 1'b1; e.upd_v = 1'b1;
      end
      8'h4C: e.len = 2'd3;
      8'hAD: begin e.len = 2'd3; e.opa = SEL_MEM; e.dest = DST_AREG; e.upd_z = 1'b1; end
      8'h8D: begin e.len = 2'd3; e.opa = SEL_AREG; e.dest = DST_MEM; end
      default: begin
`ifdef M6502_DECODE_ILLEGAL_TRAP_EN
        e.illegal = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  state_t          r_state;
  entry_t          r_cur;
  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic [15:0]     r_fetch_addr;
  logic            r_halt;

  entry_t          w_dec, w_entry, w_head;
  logic            w_final, w_full, w_accept, w_push, w_pop;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_dec       = decode(in_data);
    w_entry     = w_dec;
    w_entry.pc  = r_fetch_addr;
    w_final     = (w_dec.len == 2'd1);
    case (r_state)
      S_OP1: begin
        w_entry         = r_cur;
        w_entry.operand = {8'h00, in_data};
        w_final         = (r_cur.len == 2'd2);
      end
      S_OP2: begin
        w_entry               = r_cur;
        w_entry.operand[15:8] = in_data;
        w_final               = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign in_ready = !w_full && !flush && !r_halt;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_final;
  assign out_valid = (r_count != '0);
  assign w_pop    = out_valid && out_ready && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_OPC;
      r_cur        <= '0;
      r_fetch_addr <= RESET_PC;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_halt       <= 1'b0;
    end else if (flush) begin
      r_state      <= S_OPC;
      r_fetch_addr <= flush_pc;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_halt       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fetch_addr <= r_fetch_addr + 16'd1;
        if (w_final) begin
          r_state <= S_OPC;
        end else begin
          r_cur   <= w_entry;
          r_state <= (r_state == S_OPC) ? S_OP1 : S_OP2;
        end
      end
      if (w_push && w_entry.illegal) r_halt <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: queue storage has no reset; the head is masked by out_valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;

  assign fetch_addr       = r_fetch_addr;
  assign out_pc           = w_head.pc;
  assign out_opcode       = w_head.opcode;
  assign out_operand      = w_head.operand;
  assign out_len          = w_head.len;
  assign out_opa          = w_head.opa;
  assign out_opb          = w_head.opb;
  assign out_alu_op       = w_head.alu;
  assign out_dest         = w_head.dest;
  assign out_upd_carry    = w_head.upd_c;
  assign out_upd_zero     = w_head.upd_z;
  assign out_upd_overflow = w_head.upd_v;
  assign out_illegal      = w_head.illegal;

endmodule
